// File: rtl/enviar_datos.sv
// 8N1 serial transmitter: IDLE -> START -> DATA -> (PARITY) -> STOP.
// Define ENVIAR_DATOS_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module enviar_datos #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] datos,
    output logic       tx,
    output logic       comm_in,
    output logic       bussy_e
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef ENVIAR_DATOS_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
`ifdef ENVIAR_DATOS_PARITY_EN
    logic          par_bit;
`endif

    // tx is loaded one bit ahead, at the bit boundary, so the line is fully registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            bussy_e  <= 1'b0;
            comm_in  <= 1'b0;
`ifdef ENVIAR_DATOS_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            comm_in <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx       <= 1'b1;
                    bussy_e  <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (start) begin
                        shreg   <= datos;
`ifdef ENVIAR_DATOS_PARITY_EN
                        par_bit <= ^datos;
`endif
                        tx      <= 1'b0;
                        bussy_e <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt == LAST_CNT) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shreg[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == LAST_CNT) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef ENVIAR_DATOS_PARITY_EN
                            tx    <= par_bit;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef ENVIAR_DATOS_PARITY_EN
                S_PARITY: begin
                    if (baud_cnt == LAST_CNT) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_cnt == LAST_CNT) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        bussy_e  <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                        // Registered pulse lands on the final stop-bit cycle.
                        if (baud_cnt == PRE_LAST)
                            comm_in <= 1'b1;
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    bussy_e <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enviar_datos.sv
// Self-checking bench for enviar_datos with CLKS_PER_BIT=4; follows ENVIAR_DATOS_PARITY_EN when defined.
module tb_enviar_datos;

    localparam int C = 4;
`ifdef ENVIAR_DATOS_PARITY_EN
    localparam int L = 11;
`else
    localparam int L = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] datos = 8'h00;
    logic       tx;
    logic       comm_in;
    logic       bussy_e;

    int n_cmp = 0;
    int n_err = 0;

    enviar_datos #(.CLKS_PER_BIT(C)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .datos   (datos),
        .tx      (tx),
        .comm_in (comm_in),
        .bussy_e (bussy_e)
    );

    always #5 clk = ~clk;

    // seq lists the data bits in line order, first-sent bit in seq[7].
    typedef struct {
        logic [7:0] datos;
        logic [7:0] datos_after;
        logic [7:0] seq;
        logic       par;
    } vec_t;

    vec_t tbl[6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_frame(input vec_t v);
        logic exp_tx;
        int   p;
        start = 1'b1;
        datos = v.datos;
        tick();
        start = 1'b0;
        datos = v.datos_after;
        for (int c = 0; c < L * C; c++) begin
            p = c / C;
            if (p == 0)
                exp_tx = 1'b0;
            else if (p <= 8)
                exp_tx = v.seq[8 - p];
`ifdef ENVIAR_DATOS_PARITY_EN
            else if (p == 9)
                exp_tx = v.par;
`endif
            else
                exp_tx = 1'b1;
            chk($sformatf("frame%02h_tx_c%0d", v.datos, c), 32'(tx), 32'(exp_tx));
            chk($sformatf("frame%02h_bussy_c%0d", v.datos, c), 32'(bussy_e), 32'd1);
            chk($sformatf("frame%02h_comm_c%0d", v.datos, c), 32'(comm_in),
                32'((c == L * C - 1) ? 1 : 0));
            tick();
        end
        chk($sformatf("frame%02h_end_bussy", v.datos), 32'(bussy_e), 32'd0);
        chk($sformatf("frame%02h_end_tx", v.datos), 32'(tx), 32'd1);
        chk($sformatf("frame%02h_end_comm", v.datos), 32'(comm_in), 32'd0);
    endtask

    initial begin
        int rise[3];
        int nr;
        int ncomm;
        int t;
        logic prev_b;

        tbl[0] = '{datos: 8'h01, datos_after: 8'hFE, seq: 8'b1000_0000, par: 1'b1};
        tbl[1] = '{datos: 8'hA5, datos_after: 8'h00, seq: 8'b1010_0101, par: 1'b0};
        tbl[2] = '{datos: 8'h07, datos_after: 8'hF8, seq: 8'b1110_0000, par: 1'b1};
        tbl[3] = '{datos: 8'h80, datos_after: 8'h7F, seq: 8'b0000_0001, par: 1'b1};
        tbl[4] = '{datos: 8'h12, datos_after: 8'hED, seq: 8'b0100_1000, par: 1'b0};
        tbl[5] = '{datos: 8'h3C, datos_after: 8'hC3, seq: 8'b0011_1100, par: 1'b0};

        // Reset held with start asserted: line must stay idle.
        rst   = 1'b1;
        start = 1'b1;
        datos = 8'h5A;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("rst_tx_%0d", i), 32'(tx), 32'd1);
            chk($sformatf("rst_bussy_%0d", i), 32'(bussy_e), 32'd0);
            chk($sformatf("rst_comm_%0d", i), 32'(comm_in), 32'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_idle_tx_%0d", i), 32'(tx), 32'd1);
            chk($sformatf("post_rst_idle_bussy_%0d", i), 32'(bussy_e), 32'd0);
        end

        for (int k = 0; k < 6; k++) begin
            run_frame(tbl[k]);
            tick();
        end

        // Held start: back-to-back frames, one comm_in each.
        nr     = 0;
        ncomm  = 0;
        t      = 0;
        prev_b = bussy_e;
        start  = 1'b1;
        datos  = 8'h55;
        for (int i = 0; i < 3 * (L * C + 1) + 10 && nr < 3; i++) begin
            tick();
            t++;
            if (comm_in && nr >= 1) ncomm++;
            if (bussy_e && !prev_b) begin
                rise[nr] = t;
                nr++;
                chk($sformatf("held_start_bit_%0d", nr), 32'(tx), 32'd0);
            end
            prev_b = bussy_e;
        end
        start = 1'b0;
        chk("held_rise_count", 32'(nr), 32'd3);
        if (nr == 3) begin
            chk("held_period_1", 32'(rise[1] - rise[0]), 32'(L * C + 1));
            chk("held_period_2", 32'(rise[2] - rise[1]), 32'(L * C + 1));
        end
        chk("held_comm_count", 32'(ncomm), 32'd2);
        for (int i = 0; i < L * C + 5 && bussy_e; i++)
            tick();
        chk("held_drain_bussy", 32'(bussy_e), 32'd0);
        tick();

        // Reset during data bit 3.
        start = 1'b1;
        datos = 8'hFF;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 17; c++)
            tick();
        chk("midrst_pre_bussy", 32'(bussy_e), 32'd1);
        chk("midrst_pre_tx", 32'(tx), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_bussy", 32'(bussy_e), 32'd0);
        chk("midrst_comm", 32'(comm_in), 32'd0);
        for (int i = 0; i < L * C; i++) begin
            tick();
            chk($sformatf("midrst_quiet_bussy_%0d", i), 32'(bussy_e), 32'd0);
            chk($sformatf("midrst_quiet_comm_%0d", i), 32'(comm_in), 32'd0);
        end
        run_frame(tbl[1]);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
